clock_select_ctrl_m: RTL

//  Sequencer for the HS/LS glitch-free clock switch. Chooses HS or LS (host 2MHz) clock per CPU access.

---
 rtl/clock_select_ctrl_m_pkg.sv | 19 +
 rtl/clock_select_ctrl_m_if.sv | 22 ++
 rtl/clock_select_ctrl_m_sync.sv | 18 +
 rtl/clock_select_ctrl_m.sv | 81 ++++++++
 4 files changed

// File: rtl/clock_select_ctrl_m_pkg.sv
// Shared state codes and default parameters for the HS/LS clock-select sequencer.
package clock_select_ctrl_m_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_LS_RUN = 3'd1,
    ST_TO_HS  = 3'd2,
    ST_HS_RUN = 3'd3,
    ST_TO_LS  = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LS_DWELL    = 16;
  localparam int DEF_BOOT_CYCLES = 32;
  localparam int DEF_TIMEOUT     = 200;

endpackage

// File: rtl/clock_select_ctrl_m_if.sv
// CPU-decode and clock-switch handshake signals of the clock-select sequencer.
interface clock_select_ctrl_m_if;
  logic addr_valid_ip;
  logic need_ls_ip;
  logic force_ls_ip;
  logic selected_hs_ip;
  logic selected_ls_ip;
  logic select_hs_op;
  logic rdy_op;
  logic in_hs_op;
  logic fault_op;

  modport master (
    output addr_valid_ip, need_ls_ip, force_ls_ip, selected_hs_ip, selected_ls_ip,
    input  select_hs_op, rdy_op, in_hs_op, fault_op
  );

  modport slave (
    input  addr_valid_ip, need_ls_ip, force_ls_ip, selected_hs_ip, selected_ls_ip,
    output select_hs_op, rdy_op, in_hs_op, fault_op
  );
endinterface

// File: rtl/clock_select_ctrl_m_sync.sv
// Multi-flop synchroniser for one asynchronous status bit, synchronous active-high clear.
module sync_bit_m #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] q_pipe;

  always_ff @(posedge clk) begin
    if (clr) q_pipe <= '0;
    else     q_pipe <= {q_pipe[STAGES-2:0], d};
  end

  assign q = q_pipe[STAGES-1];
endmodule

// File: rtl/clock_select_ctrl_m.sv
// HS/LS clock switch sequencer: per-access clock choice, CPU stall during switch,
// LS dwell hysteresis and sticky handshake-timeout trap.
module clock_select_ctrl_m
  import clock_select_ctrl_m_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LS_DWELL    = DEF_LS_DWELL,
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   ck_ip,
  input  logic                   rst_ip,
  clock_select_ctrl_m_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(LS_DWELL - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hs_s, ls_s;
  logic             want_ls, want_hs;
  logic             sel_nxt, rdy_nxt, in_hs_nxt, fault_nxt;

  sync_bit_m #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk(ck_ip), .clr(rst_ip), .d(bus.selected_hs_ip), .q(hs_s)
  );
  sync_bit_m #(.STAGES(SYNC_STAGES)) u_sync_ls (
    .clk(ck_ip), .clr(rst_ip), .d(bus.selected_ls_ip), .q(ls_s)
  );

  assign want_ls = bus.force_ls_ip | (bus.addr_valid_ip & bus.need_ls_ip);
  assign want_hs = !bus.force_ls_ip & bus.addr_valid_ip & !bus.need_ls_ip;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT:   if (cnt == TMO)                           state_nxt = ST_FAULT;
                 else if (ls_s && cnt >= BOOT_LAST)        state_nxt = ST_LS_RUN;
      ST_LS_RUN: if (want_hs && cnt >= DWELL_END)          state_nxt = ST_TO_HS;
      ST_TO_HS:  if (cnt == TMO)                           state_nxt = ST_FAULT;
                 else if (hs_s && !ls_s)                   state_nxt = ST_HS_RUN;
      ST_HS_RUN: if (want_ls)                              state_nxt = ST_TO_LS;
      ST_TO_LS:  if (cnt == TMO)                           state_nxt = ST_FAULT;
                 else if (ls_s && !hs_s)                   state_nxt = ST_LS_RUN;
      ST_FAULT:  state_nxt = ST_FAULT;
      default:   state_nxt = ST_FAULT;
    endcase

    // Counter restarts on every state change so dwell/timeout are per-state.
    if (state_nxt != state)  cnt_nxt = '0;
    else if (cnt == CNT_MAX) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + 1'b1;

    sel_nxt   = (state_nxt == ST_TO_HS) || (state_nxt == ST_HS_RUN);
    in_hs_nxt = (state_nxt == ST_HS_RUN);
    fault_nxt = (state_nxt == ST_FAULT);
    rdy_nxt   = (state_nxt == ST_LS_RUN) || (state_nxt == ST_HS_RUN) ||
                ((state_nxt == ST_FAULT) && ls_s);
  end

  always_ff @(posedge ck_ip) begin
    if (rst_ip) begin
      state            <= ST_BOOT;
      cnt              <= '0;
      bus.select_hs_op <= 1'b0;
      bus.rdy_op       <= 1'b0;
      bus.in_hs_op     <= 1'b0;
      bus.fault_op     <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      bus.select_hs_op <= sel_nxt;
      bus.rdy_op       <= rdy_nxt;
      bus.in_hs_op     <= in_hs_nxt;
      bus.fault_op     <= fault_nxt;
    end
  end
endmodule
